// File: rtl/comp_seq_nbit.sv
// Multi-cycle magnitude comparator: walks WIDTH-bit operands CHUNK bits per
// clock from the MSB end and stops at the first differing chunk.
module comp_seq_nbit #(
    parameter  int WIDTH     = 16,
    parameter  int CHUNK     = 4,
    parameter  int SIGNED_EN = 1,
    localparam int NCH       = WIDTH / CHUNK,
    localparam int CW        = $clog2(NCH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic [CW-1:0]    cycles
);

    localparam int KW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] p_r, q_r;
    logic [KW-1:0]    k;
    logic [CHUNK-1:0] p_ch [NCH];
    logic [CHUNK-1:0] q_ch [NCH];
    logic [CHUNK-1:0] p_c, q_c;
    logic             accept, last, finish, flip;

    // Chunk 0 is the most significant slice of the operand.
    for (genvar g = 0; g < NCH; g++) begin : g_chunk
        assign p_ch[g] = p_r[WIDTH-1-g*CHUNK -: CHUNK];
        assign q_ch[g] = q_r[WIDTH-1-g*CHUNK -: CHUNK];
    end

    assign p_c    = p_ch[k];
    assign q_c    = q_ch[k];
    assign last   = (int'(k) == NCH - 1);
    assign finish = (p_c != q_c) || last;
    assign accept = start && ((state == IDLE) || (state == DONE));
    assign flip   = (SIGNED_EN != 0) && signed_mode;
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (finish) state_d = DONE;
            DONE:    state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Flipping the sign bit at latch time maps two's-complement order onto
    // unsigned order, so the chunk walk itself is mode-agnostic.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_r    <= '0;
            q_r    <= '0;
            k      <= '0;
            gt     <= 1'b0;
            lt     <= 1'b0;
            eq     <= 1'b0;
            cycles <= '0;
        end else begin
            if (accept) begin
                p_r <= p ^ (flip ? MSB : '0);
                q_r <= q ^ (flip ? MSB : '0);
                k   <= '0;
            end else if ((state == RUN) && !finish) begin
                k <= k + KW'(1);
            end
            if ((state == RUN) && finish) begin
                gt     <= (p_c > q_c);
                lt     <= (p_c < q_c);
                eq     <= (p_c == q_c);
                cycles <= CW'(k) + CW'(1);
            end
        end
    end

endmodule
